// File: rtl/change_dispenser.sv
// Coin-output stage of the ticket vending machine: pays out a change amount
// one coin at a time, largest available denomination first.
module change_dispenser #(
  parameter int unsigned PULSE_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_RDY,
  input  logic [7:0] DATA_in,
  input  logic [3:0] hopper_empty,
  output logic [7:0] coin_out,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_err,
  output logic [7:0] DATA_out
);

  // state    | meaning
  // IDLE     | waiting for a change request
  // SELECT   | pick largest fitting, non-empty denomination
  // PULSE    | eject one coin, deduct it from remaining
  // GAP      | PULSE_GAP quiet cycles between coins
  // DONE     | full amount paid out
  // FAULT    | remainder cannot be paid, report it
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_PULSE  = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam logic [3:0] GAP_LOAD = 4'(PULSE_GAP - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [1:0] den_q, den_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] coin_q;
  logic       busy_q, done_q, err_q;
  logic [7:0] data_q;

  logic       pick_ok;
  logic [1:0] pick_idx;

  // Denomination index: 0 -> 1, 1 -> 2, 2 -> 5, 3 -> 10 (matches hopper_empty bits).
  function automatic logic [7:0] den_value(input logic [1:0] idx);
    case (idx)
      2'd3:    den_value = 8'd10;
      2'd2:    den_value = 8'd5;
      2'd1:    den_value = 8'd2;
      default: den_value = 8'd1;
    endcase
  endfunction

  always_comb begin
    pick_ok  = 1'b1;
    pick_idx = 2'd3;
    if (!hopper_empty[3] && rem_q >= 8'd10)      pick_idx = 2'd3;
    else if (!hopper_empty[2] && rem_q >= 8'd5)  pick_idx = 2'd2;
    else if (!hopper_empty[1] && rem_q >= 8'd2)  pick_idx = 2'd1;
    else if (!hopper_empty[0] && rem_q >= 8'd1)  pick_idx = 2'd0;
    else                                         pick_ok  = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    den_d   = den_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (in_RDY) begin
          rem_d   = DATA_in;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (rem_q == 8'd0) begin
          state_d = S_DONE;
        end else if (pick_ok) begin
          den_d   = pick_idx;
          state_d = S_PULSE;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_PULSE: begin
        rem_d   = rem_q - den_value(den_q);
        gap_d   = GAP_LOAD;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_SELECT;
        else               gap_d   = gap_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= 8'd0;
      den_q   <= 2'd0;
      gap_q   <= 4'd0;
      coin_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      gap_q   <= gap_d;
      coin_q  <= (state_d == S_PULSE) ? (8'd1 << den_d) : 8'd0;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_FAULT);
      if (state_d == S_DONE)       data_q <= 8'd0;
      else if (state_d == S_FAULT) data_q <= rem_d;
    end
  end

  assign coin_out = coin_q;
  assign out_busy = busy_q;
  assign out_done = done_q;
  assign out_err  = err_q;
  assign DATA_out = data_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: a per-request timeline model predicts
// every output cycle, and a negedge process compares the DUT against it.
module tb_change_dispenser;

  localparam int G    = 2;
  localparam int MAXC = 1100;

  logic       clk = 1'b0;
  logic       rst, in_RDY;
  logic [7:0] DATA_in;
  logic [3:0] hopper_empty;
  logic [7:0] coin_out, DATA_out;
  logic       out_busy, out_done, out_err;

  change_dispenser #(.PULSE_GAP(G)) dut (
    .clk(clk), .rst(rst), .in_RDY(in_RDY), .DATA_in(DATA_in),
    .hopper_empty(hopper_empty), .coin_out(coin_out), .out_busy(out_busy),
    .out_done(out_done), .out_err(out_err), .DATA_out(DATA_out)
  );

  always #5 clk = ~clk;

  logic [3:0] hop    [0:MAXC-1];
  logic [7:0] m_coin [0:MAXC-1];
  logic       m_busy [0:MAXC-1];
  logic       m_done [0:MAXC-1];
  logic       m_err  [0:MAXC-1];
  logic [7:0] m_data [0:MAXC-1];
  int         m_end;
  logic [7:0] data_hold;

  logic [7:0] exp_coin, exp_data;
  logic       exp_busy, exp_done, exp_err;
  bit         chk_en = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("coin_out", int'(coin_out), int'(exp_coin));
      chk("out_busy", int'(out_busy), int'(exp_busy));
      chk("out_done", int'(out_done), int'(exp_done));
      chk("out_err",  int'(out_err),  int'(exp_err));
      chk("DATA_out", int'(DATA_out), int'(exp_data));
    end
  end

  // Timeline of one request from greedy change-making; cycle 0 is the in_RDY cycle.
  task automatic build_model(input int amount);
    int den[4]  = '{10, 5, 2, 1};
    int bitn[4] = '{3, 2, 1, 0};
    int rem, s, pick, val;
    for (int t = 0; t < MAXC; t++) begin
      m_coin[t] = 8'd0; m_busy[t] = 1'b0; m_done[t] = 1'b0;
      m_err[t] = 1'b0;  m_data[t] = data_hold;
    end
    rem = amount;
    s   = 1;
    val = 0;
    forever begin
      m_busy[s] = 1'b1;
      if (rem == 0) begin
        m_end = s + 1; m_done[m_end] = 1'b1; val = 0;
        break;
      end
      pick = -1;
      for (int i = 0; i < 4; i++)
        if (pick < 0 && !hop[s][bitn[i]] && den[i] <= rem) pick = i;
      if (pick < 0) begin
        m_end = s + 1; m_err[m_end] = 1'b1; val = rem;
        break;
      end
      for (int k = 1; k <= 1 + G; k++) m_busy[s+k] = 1'b1;
      m_coin[s+1] = 8'(1 << bitn[pick]);
      rem -= den[pick];
      s += 2 + G;
    end
    m_busy[m_end] = 1'b1;
    for (int t = m_end; t < MAXC; t++) m_data[t] = 8'(val);
  endtask

  task automatic fill_hop(input logic [3:0] a, input logic [3:0] b, input int sw);
    for (int t = 0; t < MAXC; t++) hop[t] = (t < sw) ? a : b;
  endtask

  function automatic logic [3:0] rand_mask();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = ($urandom_range(3) == 0);
    return m;
  endfunction

  task automatic set_idle_exp();
    exp_coin = 8'd0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    exp_data = data_hold;
  endtask

  task automatic run_req(input int amount, input int abort_at, input bit noise);
    int last;
    build_model(amount);
    last = (abort_at > 0) ? abort_at : m_end;
    for (int t = 0; t <= last; t++) begin
      rst          = (abort_at > 0 && t == abort_at);
      in_RDY       = (t == 0) || (noise && $urandom_range(1) == 0);
      DATA_in      = (t == 0) ? 8'(amount) : (noise ? 8'd7 : 8'($urandom_range(255)));
      hopper_empty = hop[t];
      @(posedge clk); #1;
      if (abort_at > 0 && t == abort_at) begin
        data_hold = 8'd0;
        set_idle_exp();
      end else begin
        exp_coin = m_coin[t+1]; exp_busy = m_busy[t+1]; exp_done = m_done[t+1];
        exp_err  = m_err[t+1];  exp_data = m_data[t+1];
      end
    end
    rst    = 1'b0;
    in_RDY = 1'b0;
    if (abort_at == 0) data_hold = m_data[m_end];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_RDY = 1'b0;
      DATA_in = 8'($urandom_range(255));
      hopper_empty = rand_mask();
      @(posedge clk); #1;
      set_idle_exp();
    end
  endtask

  initial begin
    int amt, ab;
    rst = 1'b1; in_RDY = 1'b0; DATA_in = 8'd0; hopper_empty = 4'd0;
    data_hold = 8'd0;
    set_idle_exp();
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Pin the model to hand-computed timelines.
    fill_hop(4'b0000, 4'b0000, MAXC);
    build_model(18);
    chk("model18_c2",  int'(m_coin[2]),  8);
    chk("model18_c6",  int'(m_coin[6]),  4);
    chk("model18_c10", int'(m_coin[10]), 2);
    chk("model18_c14", int'(m_coin[14]), 1);
    chk("model18_end", m_end, 18);
    build_model(255);
    chk("model255_end", m_end, 106);
    chk("model255_c98",  int'(m_coin[98]),  8);
    chk("model255_c102", int'(m_coin[102]), 4);
    fill_hop(4'b0011, 4'b0011, MAXC);
    build_model(3);
    chk("model3_end",  m_end, 2);
    chk("model3_err",  int'(m_err[2]), 1);
    chk("model3_data", int'(m_data[2]), 3);
    chk("model3_busy3", int'(m_busy[3]), 0);
    fill_hop(4'b0100, 4'b0100, MAXC);
    build_model(8);
    chk("model8_c14", int'(m_coin[14]), 2);
    chk("model8_end", m_end, 18);

    // Directed scenarios.
    fill_hop(4'b0000, 4'b0000, MAXC); run_req(18, 0, 1'b0); idle(2);
    fill_hop(4'b0100, 4'b0100, MAXC); run_req(8, 0, 1'b0);  idle(1);
    fill_hop(4'b0011, 4'b0011, MAXC); run_req(3, 0, 1'b0);  idle(1);
    fill_hop(4'b0000, 4'b0000, MAXC); run_req(255, 0, 1'b0);
    run_req(18, 0, 1'b1); idle(1);
    run_req(18, 7, 1'b0);
    run_req(0, 0, 1'b0); idle(1);
    rst = 1'b1; in_RDY = 1'b1; DATA_in = 8'd50;
    @(posedge clk); #1;
    data_hold = 8'd0;
    set_idle_exp();
    rst = 1'b0; in_RDY = 1'b0;
    idle(2);
    fill_hop(4'b0000, 4'b1000, 6); run_req(30, 0, 1'b0); idle(1);

    for (int n = 0; n < 40; n++) begin
      amt = ($urandom_range(3) == 0) ? int'($urandom_range(20)) : int'($urandom_range(255));
      fill_hop(rand_mask(), rand_mask(), int'($urandom_range(60, 1)));
      build_model(amt);
      ab = ($urandom_range(7) == 0) ? int'($urandom_range(m_end, 1)) : 0;
      run_req(amt, ab, 1'($urandom_range(1)));
      idle(int'($urandom_range(2)));
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-output end of the ticket vending machine. It accepts a change amount from the fare and coin-accounting logic with a one-cycle ready strobe. It then drives the coin hoppers one coin at a time, largest available denomination first, with a programmable gap between coin pulses. It ends each request with either a done strobe or an error strobe that reports the undispensed remainder. It is the counterpart of the coin-insertion stage and uses the same one-hot coin encoding on its output.

## Interface
- PULSE_GAP, 2, idle cycles (coin_out = 0) after each coin pulse; legal range 1..15.
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset; synchronous, active-high.
- in_RDY  in  1  one-cycle strobe: DATA_in is valid.
- DATA_in  in  8  change amount in units, 0..255.
- hopper_empty  in  4  per-denomination empty flags, one bit per denomination: bit0 = 1, bit1 = 2, bit2 = 5, bit3 = 10.
- coin_out  out  8  one-hot coin eject pulse.
  - 8'b0000_0001 = 1, 8'b0000_0010 = 2, 8'b0000_0100 = 5, 8'b0000_1000 = 10.
  - Bits 7:4 are always 0.
- out_busy  out  1  high from the cycle after an accepted in_RDY until the done/error cycle, inclusive.
- out_done  out  1  one-cycle strobe: full amount dispensed.
- out_err  out  1  one-cycle strobe: remainder cannot be dispensed.
- DATA_out  out  8  remainder not dispensed; valid on the out_done/out_err cycle (0 on done), held until the next request.

## Operation
- State machine states: IDLE, SELECT, PULSE, GAP, DONE, FAULT.
- IDLE:
  - On in_RDY = 1, load DATA_in into an 8-bit `remaining` register and go to SELECT.
  - in_RDY is ignored in every other state: no queueing, and no change to `remaining`.
- SELECT:
  - Sample hopper_empty in this state only.
  - Pick the largest d in {10, 5, 2, 1} such that d <= remaining and hopper_empty[d] = 0.
  - If remaining = 0, go to DONE.
  - Else if a d exists, latch it and go to PULSE.
  - Else go to FAULT.
- PULSE: drive coin_out one-hot for d for exactly 1 cycle, set remaining <= remaining - d, then go to GAP. The subtraction cannot underflow because d <= remaining.
- GAP: coin_out = 0 for PULSE_GAP cycles, counted by a 4-bit counter, then go to SELECT.
- DONE: out_done = 1 and DATA_out = 0 for 1 cycle, then go to IDLE.
- FAULT: out_err = 1 and DATA_out = remaining for 1 cycle, then go to IDLE.
- A hopper that empties mid-request is bypassed at the next SELECT; no error is raised while a smaller denomination can still fit.
- Reset values: state IDLE, remaining 0, gap counter 0, coin_out 0, out_busy 0, out_done 0, out_err 0, DATA_out 0.
- Reset mid-request: on the next edge the block is in IDLE with all outputs 0. The remainder is discarded and no done/error strobe is issued.
- in_RDY asserted together with rst: rst wins and the request is lost.

## Timing
- All outputs are registered.
- in_RDY is sampled at cycle 0; SELECT is cycle 1.
- Each coin costs 2 + PULSE_GAP cycles: SELECT, PULSE, then GAP.
- Amount 0: out_done at cycle 2; coin_out is never asserted.
- Amount with n coins: out_done at cycle 2 + n·(2 + PULSE_GAP).
- FAULT with no coins dispensed: out_err at cycle 2.
- out_busy rises at cycle 1 and falls the cycle after the done/error strobe.
- A new in_RDY is accepted on the first IDLE cycle after DONE/FAULT.
- At most one coin_out bit is high in any cycle.
- Consecutive coin pulses are separated by at least PULSE_GAP + 1 zero cycles.

## Test plan
- 18, all hoppers full, PULSE_GAP = 2:
  - Pulses 10, 5, 2, 1 at cycles 2, 6, 10, 14.
  - out_done at cycle 18 with DATA_out = 0.
- 8, with hopper_empty = 4'b0100 (no 5s): pulses 2, 2, 2, 2; out_done; DATA_out = 0.
- 3, with hopper_empty = 4'b0011:
  - No coin pulses.
  - out_err at cycle 2 with DATA_out = 3.
  - out_busy high for cycles 1..2 only.
- 255, all full: 25 pulses of 10, then 1 pulse of 5; out_done at cycle 2 + 26·4 = 106.
- 18 with in_RDY re-pulsed (DATA_in = 7) during GAP: the second strobe is ignored and the sequence stays 10, 5, 2, 1.
- Reset during the second GAP of 18, then 0 requested afterwards:
  - After reset, all outputs are 0 and no out_done is issued for the aborted request.
  - The following request for 0 yields out_done at cycle 2.
